flag_unit: RTL and testbench

- Architectural flags register that produces the {c,o,s,z} vector consumed by the jump-condition evaluator.
- Computes flags from ALU operands and opcode, and supports explicit flag loads (popf).
- Holds a DEPTH-entry shadow stack that saves and restores flags on interrupt entry and return.
- Sits between ALU issue and branch resolution; the flags_o port drives the condition evaluator directly.

---
 rtl/flag_unit.sv | 172 +++++++++++++++++
 tb/tb_flag_unit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/flag_unit.sv
// Architectural {c,o,s,z} flags register with ALU flag generation, explicit loads
// and a DEPTH-entry LIFO shadow stack for interrupt save/restore.
module flag_unit #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         upd_valid,
  input  logic [2:0]                   upd_op,
  input  logic [3:0]                   upd_mask,
  input  logic [WIDTH-1:0]             upd_a,
  input  logic [WIDTH-1:0]             upd_b,
  input  logic                         ld_valid,
  input  logic [3:0]                   ld_flags,
  input  logic                         irq_save,
  input  logic                         irq_restore,
  input  logic                         err_clr,
  output logic [3:0]                   flags_o,
  output logic [$clog2(DEPTH+1)-1:0]   depth_o,
  output logic                         ovf_o,
  output logic                         unf_o
);

  localparam int DW  = $clog2(DEPTH+1);
  localparam int MSB = WIDTH - 1;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_ADC  = 3'b001,
    OP_SUB  = 3'b010,
    OP_SBB  = 3'b011,
    OP_AND  = 3'b100,
    OP_OR   = 3'b101,
    OP_XOR  = 3'b110,
    OP_SHR1 = 3'b111
  } op_e;

  logic [3:0]       r_flags;
  logic [DW-1:0]    r_depth;
  logic             r_ovf;
  logic             r_unf;
  logic [3:0]       r_stack [DEPTH];

  op_e              w_op;
  logic             w_cin;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_dif;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_o;
  logic [3:0]       w_alu_flags;
  logic [3:0]       w_norm_flags;
  logic [3:0]       w_next_flags;
  logic             w_empty;
  logic             w_full;
  logic [DW-1:0]    w_top_idx;
  logic [3:0]       w_top;
  logic             w_pop;
  logic             w_push;
  logic             w_swap;
  logic             w_ovf_evt;
  logic             w_unf_evt;
  logic [DW-1:0]    w_next_depth;
  logic             w_wr_en;
  logic [DW-1:0]    w_wr_idx;
  logic [3:0]       w_wr_data;

  assign w_op  = op_e'(upd_op);
  assign w_cin = ((w_op == OP_ADC) || (w_op == OP_SBB)) && r_flags[3];
  assign w_sum = {1'b0, upd_a} + {1'b0, upd_b} + {{WIDTH{1'b0}}, w_cin};
  // Bit WIDTH of the extended difference is the borrow (a < b + cin).
  assign w_dif = {1'b0, upd_a} - {1'b0, upd_b} - {{WIDTH{1'b0}}, w_cin};

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_o   = 1'b0;
    unique case (w_op)
      OP_ADD, OP_ADC: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_o   = (upd_a[MSB] == upd_b[MSB]) && (w_sum[MSB] != upd_a[MSB]);
      end
      OP_SUB, OP_SBB: begin
        w_res = w_dif[WIDTH-1:0];
        w_c   = w_dif[WIDTH];
        w_o   = (upd_a[MSB] != upd_b[MSB]) && (w_dif[MSB] != upd_a[MSB]);
      end
      OP_AND:  w_res = upd_a & upd_b;
      OP_OR:   w_res = upd_a | upd_b;
      OP_XOR:  w_res = upd_a ^ upd_b;
      OP_SHR1: begin
        w_res = upd_a >> 1;
        w_c   = upd_a[0];
      end
      default: ;
    endcase
  end

  assign w_alu_flags = {w_c, w_o, w_res[MSB], (w_res == '0)};

  always_comb begin
    w_norm_flags = r_flags;
    if (ld_valid)
      w_norm_flags = ld_flags;
    else if (upd_valid)
      w_norm_flags = (r_flags & ~upd_mask) | (w_alu_flags & upd_mask);
  end

  assign w_empty   = (r_depth == '0);
  assign w_full    = (r_depth == DW'(DEPTH));
  assign w_top_idx = w_empty ? '0 : r_depth - 1'b1;
  assign w_top     = r_stack[w_top_idx];

  // A restore with a non-empty stack owns the cycle; a simultaneous save turns it into a swap.
  assign w_pop     = irq_restore && !w_empty;
  assign w_swap    = irq_save && w_pop;
  assign w_push    = irq_save && !w_pop && !w_full;
  assign w_ovf_evt = irq_save && !irq_restore && w_full;
  assign w_unf_evt = irq_restore && w_empty;

  assign w_next_flags = w_pop ? w_top : w_norm_flags;

  always_comb begin
    w_next_depth = r_depth;
    if (w_push)
      w_next_depth = r_depth + 1'b1;
    else if (w_pop && !w_swap)
      w_next_depth = r_depth - 1'b1;
  end

  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_idx  = r_depth;
    w_wr_data = w_next_flags;
    if (w_push) begin
      w_wr_en = 1'b1;
    end else if (w_swap) begin
      w_wr_en   = 1'b1;
      w_wr_idx  = w_top_idx;
      w_wr_data = r_flags;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags <= '0;
      r_depth <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_flags <= w_next_flags;
      r_depth <= w_next_depth;
      r_ovf   <= w_ovf_evt | (r_ovf & ~err_clr);
      r_unf   <= w_unf_evt | (r_unf & ~err_clr);
    end
  end

  // NOTE: stack storage has no reset; entries above depth are never read, so clearing them buys nothing.
  always_ff @(posedge clk) begin
    if (w_wr_en)
      r_stack[w_wr_idx] <= w_wr_data;
  end

  assign flags_o = r_flags;
  assign depth_o = r_depth;
  assign ovf_o   = r_ovf;
  assign unf_o   = r_unf;

endmodule

// File: tb/tb_flag_unit.sv
// Self-checking bench for flag_unit: directed scenarios plus random traffic,
// all checked against a queue-based reference model of the flags/stack rules.
module tb_flag_unit;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int DW    = $clog2(DEPTH+1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             upd_valid;
  logic [2:0]       upd_op;
  logic [3:0]       upd_mask;
  logic [WIDTH-1:0] upd_a;
  logic [WIDTH-1:0] upd_b;
  logic             ld_valid;
  logic [3:0]       ld_flags;
  logic             irq_save;
  logic             irq_restore;
  logic             err_clr;
  logic [3:0]       flags_o;
  logic [DW-1:0]    depth_o;
  logic             ovf_o;
  logic             unf_o;

  flag_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .upd_valid(upd_valid), .upd_op(upd_op), .upd_mask(upd_mask),
    .upd_a(upd_a), .upd_b(upd_b),
    .ld_valid(ld_valid), .ld_flags(ld_flags),
    .irq_save(irq_save), .irq_restore(irq_restore), .err_clr(err_clr),
    .flags_o(flags_o), .depth_o(depth_o), .ovf_o(ovf_o), .unf_o(unf_o)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [3:0] m_flags;
  logic [3:0] m_stack[$];
  logic       m_ovf;
  logic       m_unf;

  int n_cmp  = 0;
  int n_fail = 0;

  // Flags from the arithmetic meaning of each op: unsigned range for carry/borrow,
  // signed range for overflow.
  function automatic logic [3:0] ref_alu(input logic [2:0] op, input longint a,
                                         input longint b, input longint cin);
    longint full, sa, sb, sres, res;
    logic   c, o;
    sa = (a >= 2**(WIDTH-1)) ? a - 2**WIDTH : a;
    sb = (b >= 2**(WIDTH-1)) ? b - 2**WIDTH : b;
    c = 1'b0; o = 1'b0; res = 0;
    case (op)
      3'd0, 3'd1: begin
        full = a + b + cin;
        c    = (full >= 2**WIDTH);
        res  = full % (2**WIDTH);
        sres = sa + sb + cin;
        o    = (sres > 2**(WIDTH-1) - 1) || (sres < -(2**(WIDTH-1)));
      end
      3'd2, 3'd3: begin
        c    = (a < b + cin);
        res  = (a - b - cin + 2**(WIDTH+1)) % (2**WIDTH);
        sres = sa - sb - cin;
        o    = (sres > 2**(WIDTH-1) - 1) || (sres < -(2**(WIDTH-1)));
      end
      3'd4: res = a & b;
      3'd5: res = a | b;
      3'd6: res = a ^ b;
      default: begin
        res = a / 2;
        c   = (a % 2) == 1;
      end
    endcase
    return {c, o, (res >= 2**(WIDTH-1)), (res == 0)};
  endfunction

  task automatic model_reset();
    m_flags = '0;
    m_stack.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic model_step();
    logic [3:0] alu, norm, nf;
    logic       ovf_evt, unf_evt;
    longint     cin;
    cin  = ((upd_op == 3'd1) || (upd_op == 3'd3)) ? longint'(m_flags[3]) : 0;
    alu  = ref_alu(upd_op, longint'(upd_a), longint'(upd_b), cin);
    norm = ld_valid ? ld_flags :
           upd_valid ? ((m_flags & ~upd_mask) | (alu & upd_mask)) : m_flags;
    ovf_evt = 1'b0;
    unf_evt = 1'b0;
    nf = norm;
    if (irq_save && irq_restore) begin
      if (m_stack.size() > 0) begin
        nf = m_stack[m_stack.size()-1];
        m_stack[m_stack.size()-1] = m_flags;
      end else begin
        m_stack.push_back(norm);
        unf_evt = 1'b1;
      end
    end else if (irq_restore) begin
      if (m_stack.size() > 0) nf = m_stack.pop_back();
      else unf_evt = 1'b1;
    end else if (irq_save) begin
      if (m_stack.size() < DEPTH) m_stack.push_back(norm);
      else ovf_evt = 1'b1;
    end
    m_flags = nf;
    m_ovf = ovf_evt | (m_ovf & ~err_clr);
    m_unf = unf_evt | (m_unf & ~err_clr);
  endtask

  task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check4({tag, ".flags"}, flags_o, m_flags);
    check4({tag, ".depth"}, 4'(depth_o), 4'(m_stack.size()));
    check4({tag, ".ovf"},   4'(ovf_o),   4'(m_ovf));
    check4({tag, ".unf"},   4'(unf_o),   4'(m_unf));
  endtask

  task automatic idle();
    upd_valid = 0; upd_op = '0; upd_mask = '0; upd_a = '0; upd_b = '0;
    ld_valid = 0; ld_flags = '0; irq_save = 0; irq_restore = 0; err_clr = 0;
  endtask

  // Apply the currently driven inputs for one clock edge and compare afterwards.
  task automatic cycle(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
    idle();
  endtask

  task automatic alu(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                     input logic [3:0] mask);
    upd_valid = 1; upd_op = op; upd_a = a; upd_b = b; upd_mask = mask;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    alu(3'd0, 16'h7FFF, 16'h0001, 4'b1111); cycle("add");
    check4("add.const", flags_o, 4'b0110);
    alu(3'd2, 16'h0000, 16'h0001, 4'b1111); cycle("sub");
    check4("sub.const", flags_o, 4'b1010);
    alu(3'd1, 16'hFFFF, 16'h0000, 4'b1111); cycle("adc");
    check4("adc.const", flags_o, 4'b1001);
    alu(3'd4, 16'h00F0, 16'h0F00, 4'b0111); cycle("and_mask");
    check4("and.const", flags_o, 4'b1001);
    alu(3'd7, 16'h0001, 16'h1234, 4'b1111); cycle("shr1");
    check4("shr1.const", flags_o, 4'b1001);
    alu(3'd3, 16'h0005, 16'h0005, 4'b1111); cycle("sbb");
    check4("sbb.const", flags_o, 4'b1010);

    ld_valid = 1; ld_flags = 4'b0001; cycle("ld");
    ld_valid = 1; ld_flags = 4'b0100; irq_save = 1; cycle("save_ld");
    check4("save_ld.depth", 4'(depth_o), 4'd1);
    irq_restore = 1; cycle("restore");
    irq_restore = 1; cycle("restore_empty");
    check4("unf.set", 4'(unf_o), 4'd1);
    err_clr = 1; cycle("err_clr");
    check4("unf.clr", 4'(unf_o), 4'd0);

    for (int i = 0; i <= DEPTH; i++) begin
      ld_valid = 1; ld_flags = 4'(i + 3); irq_save = 1; cycle("push");
    end
    check4("full.depth", 4'(depth_o), 4'(DEPTH));
    check4("ovf.set", 4'(ovf_o), 4'd1);
    irq_restore = 1; irq_save = 0; err_clr = 1; cycle("pop_clr");
    for (int i = 1; i < DEPTH; i++) begin
      irq_restore = 1; cycle("pop");
    end

    ld_valid = 1; ld_flags = 4'b0010; irq_save = 1; cycle("swap_prep");
    ld_valid = 1; ld_flags = 4'b1000; cycle("swap_ld");
    irq_save = 1; irq_restore = 1; cycle("swap");
    check4("swap.flags", flags_o, 4'b0010);
    irq_restore = 1; cycle("swap_top");
    check4("swap_top.flags", flags_o, 4'b1000);
    irq_save = 1; irq_restore = 1; cycle("swap_empty");

    repeat (400) begin
      upd_valid   = $urandom_range(0, 1);
      upd_op      = 3'($urandom_range(0, 7));
      upd_mask    = 4'($urandom);
      upd_a       = ($urandom_range(0, 3) == 0) ? 16'h8000 : 16'($urandom);
      upd_b       = ($urandom_range(0, 3) == 0) ? upd_a : 16'($urandom);
      ld_valid    = ($urandom_range(0, 5) == 0);
      ld_flags    = 4'($urandom);
      irq_save    = ($urandom_range(0, 3) == 0);
      irq_restore = ($urandom_range(0, 3) == 0);
      err_clr     = ($urandom_range(0, 9) == 0);
      cycle("rand");
    end

    ld_valid = 1; ld_flags = 4'b1111; irq_save = 1; cycle("pre_reset");
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
